// File: rtl/unidade_controle_rodadas_pkg.sv
// Shared state codes for the round-based memory game controller.
// The datapath and the 7-segment debug decoder use the same encoding.
package unidade_controle_rodadas_pkg;

    localparam int unsigned ESTADO_W = 4;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOS    = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERRO       = 4'hE
    } estado_t;

    // Shown on db_estado while the state register holds an unused code.
    localparam logic [ESTADO_W-1:0] DB_INVALID = 4'hF;

endpackage

// File: rtl/unidade_controle_rodadas_contador_timeout.sv
// Per-move timeout counter: counts while enabled, saturates at TIMEOUT-1.
// Ports:
//   i_clock  - system clock, rising edge
//   i_reset  - asynchronous active-low reset
//   i_clear  - synchronous clear (has priority over enable)
//   i_enable - count one step per cycle
//   o_tc     - high while the count sits at TIMEOUT-1
module contador_timeout #(
    parameter int unsigned TIMEOUT = 5000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] r_tmr;

    // Saturating up-counter so a long wait with timeout disabled never wraps.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_tmr <= '0;
        end else if (i_clear) begin
            r_tmr <= '0;
        end else if (i_enable && (r_tmr != TMR_MAX)) begin
            r_tmr <= r_tmr + TMR_W'(1);
        end
    end

    assign o_tc = (r_tmr == TMR_MAX);

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Moore control unit for the multi-round memory game. Round r asks the
// player to repeat r+1 moves; drives the datapath address counter (E),
// round counter (L) and move register (R), with an optional move timeout.
// Ports:
//   clock, reset          - rising-edge clock, async active-low reset
//   iniciar               - start / restart request (level)
//   jogada                - one-cycle pulse per player move
//   igual                 - registered move matches stored move at E
//   enderecoIgualRodada   - E == L (last move of the round)
//   fimRodadas            - L is the last round
//   modo_timeout          - 1 enables the move timeout
//   zeraE/contaE          - clear / increment address counter
//   zeraL/contaL          - clear / increment round counter
//   zeraR/registraR       - clear / load move register
//   pronto                - game over (any outcome)
//   ganhou/perdeu/timeout - outcome flags, valid while pronto
//   db_estado             - current state code for debug
module unidade_controle_rodadas
    import unidade_controle_rodadas_pkg::*;
#(
    parameter int unsigned TIMEOUT = 5000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                jogada,
    input  logic                igual,
    input  logic                enderecoIgualRodada,
    input  logic                fimRodadas,
    input  logic                modo_timeout,
    output logic                zeraE,
    output logic                contaE,
    output logic                zeraL,
    output logic                contaL,
    output logic                zeraR,
    output logic                registraR,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                timeout,
    output logic [ESTADO_W-1:0] db_estado
);

    estado_t r_estado;
    estado_t w_prox;
    logic    w_em_espera;
    logic    w_limpa_tmr;
    logic    w_tc;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_prox;
        end
    end

    assign w_em_espera = (r_estado == ESPERA_JOGADA);
    assign w_limpa_tmr = !w_em_espera;

    // Timer runs only while waiting for a move and restarts for every move.
    contador_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_contador_timeout (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_clear  (w_limpa_tmr),
        .i_enable (w_em_espera),
        .o_tc     (w_tc)
    );

    // Next-state and Moore output decode.
    always_comb begin
        w_prox    = r_estado;
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraL     = 1'b0;
        contaL    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        ganhou    = 1'b0;
        perdeu    = 1'b0;
        timeout   = 1'b0;
        db_estado = r_estado;

        case (r_estado)
            INICIAL: begin
                zeraE = 1'b1;
                zeraL = 1'b1;
                zeraR = 1'b1;
                if (iniciar) w_prox = PREPARACAO;
            end
            PREPARACAO: begin
                zeraE  = 1'b1;
                zeraL  = 1'b1;
                zeraR  = 1'b1;
                w_prox = INICIA_RODADA;
            end
            INICIA_RODADA: begin
                zeraE  = 1'b1;
                w_prox = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                // A move arriving on the expiry cycle still counts.
                if (jogada) begin
                    w_prox = REGISTRA;
                end else if (modo_timeout && w_tc) begin
                    w_prox = FIM_TIMEOUT;
                end
            end
            REGISTRA: begin
                registraR = 1'b1;
                w_prox    = COMPARACAO;
            end
            COMPARACAO: begin
                if (!igual) begin
                    w_prox = FIM_ERRO;
                end else if (!enderecoIgualRodada) begin
                    w_prox = PROXIMA_JOGADA;
                end else if (fimRodadas) begin
                    w_prox = FIM_ACERTOS;
                end else begin
                    w_prox = PROXIMA_RODADA;
                end
            end
            PROXIMA_JOGADA: begin
                contaE = 1'b1;
                w_prox = ESPERA_JOGADA;
            end
            PROXIMA_RODADA: begin
                contaL = 1'b1;
                w_prox = INICIA_RODADA;
            end
            FIM_ACERTOS: begin
                pronto = 1'b1;
                ganhou = 1'b1;
                if (iniciar) w_prox = PREPARACAO;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
                if (iniciar) w_prox = PREPARACAO;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                perdeu = 1'b1;
                if (iniciar) w_prox = PREPARACAO;
            end
            default: begin
                w_prox    = INICIAL;
                db_estado = DB_INVALID;
            end
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Self-checking bench for unidade_controle_rodadas (TIMEOUT=8).
// Expected behaviour is a per-cycle trace built from game rules (rounds,
// moves, idle waits, wrong moves, timeouts) and compared cycle by cycle.
module tb_unidade_controle_rodadas;

    localparam int unsigned TO = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       enderecoIgualRodada;
    logic       fimRodadas;
    logic       modo_timeout;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic       pronto, ganhou, perdeu, timeout;
    logic [3:0] db_estado;
    logic [9:0] w_outs;

    assign w_outs = {zeraE, contaE, zeraL, contaL, zeraR, registraR,
                     pronto, ganhou, perdeu, timeout};

    unidade_controle_rodadas #(.TIMEOUT(TO)) dut (
        .clock               (clock),
        .reset               (reset),
        .iniciar             (iniciar),
        .jogada              (jogada),
        .igual               (igual),
        .enderecoIgualRodada (enderecoIgualRodada),
        .fimRodadas          (fimRodadas),
        .modo_timeout        (modo_timeout),
        .zeraE               (zeraE),
        .contaE              (contaE),
        .zeraL               (zeraL),
        .contaL              (contaL),
        .zeraR               (zeraR),
        .registraR           (registraR),
        .pronto              (pronto),
        .ganhou              (ganhou),
        .perdeu              (perdeu),
        .timeout             (timeout),
        .db_estado           (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        int st;
        bit jog;
        bit ini;
        bit ig;
        bit eir;
        bit fim;
        bit modo;
    } rec_t;

    rec_t plan[$];
    int   obs[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cnt_ce = 0;
    int   cnt_cl = 0;
    bit   g_modo = 1'b1;

    // Output table: which outputs are high in each state code.
    function automatic logic [9:0] exp_outs(input int s);
        exp_outs = {(s == 0) || (s == 1) || (s == 2), (s == 6),
                    (s == 0) || (s == 1), (s == 7),
                    (s == 0) || (s == 1), (s == 4),
                    (s == 10) || (s == 13) || (s == 14),
                    (s == 10), (s == 14), (s == 13)};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0;
        enderecoIgualRodada = 1'b0; fimRodadas = 1'b0; modo_timeout = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic push(input int st, input bit jog, input bit ini,
                        input bit ig, input bit eir, input bit fim);
        rec_t r;
        r.st = st; r.jog = jog; r.ini = ini; r.ig = ig;
        r.eir = eir; r.fim = fim; r.modo = g_modo;
        plan.push_back(r);
    endtask

    // One game from preparacao to a held end state followed by a restart.
    task automatic add_game(input int nr, input int w_fix, input int wrong_r,
                            input int wrong_e, input bit rnd);
        int w;
        bit wrong;
        bit done;
        int fim_st;
        done   = 1'b0;
        fim_st = 10;
        push(1, 0, 0, 0, 0, 0);
        for (int r = 0; r < nr && !done; r++) begin
            push(2, 0, 0, 0, 0, 0);
            for (int e = 0; e <= r && !done; e++) begin
                if (rnd) begin
                    w     = g_modo ? int'($urandom_range(9, 0)) : int'($urandom_range(13, 0));
                    wrong = ($urandom_range(15, 0) == 0);
                end else begin
                    w     = w_fix;
                    wrong = (r == wrong_r) && (e == wrong_e);
                end
                if (g_modo && w >= int'(TO)) begin
                    repeat (TO) push(3, 0, 0, 0, 0, 0);
                    fim_st = 13;
                    done   = 1'b1;
                end else begin
                    repeat (w) push(3, 0, 0, 0, 0, 0);
                    push(3, 1, 0, 0, 0, 0);
                    push(4, 0, 0, 0, 0, 0);
                    push(5, 0, 0, !wrong, (e == r), (r == nr - 1));
                    if (wrong) begin
                        fim_st = 14;
                        done   = 1'b1;
                    end else if (e < r) begin
                        push(6, 0, 0, 0, 0, 0);
                    end else if (r == nr - 1) begin
                        fim_st = 10;
                        done   = 1'b1;
                    end else begin
                        push(7, 0, 0, 0, 0, 0);
                    end
                end
            end
        end
        push(fim_st, 0, 0, 0, 0, 0);
        push(fim_st, 0, 0, 0, 0, 0);
        push(fim_st, 0, 1, 0, 0, 0);
    endtask

    // Plays the queued trace; inputs irrelevant to a state are randomised.
    task automatic run_plan();
        int s;
        obs.delete();
        cnt_ce = 0;
        cnt_cl = 0;
        foreach (plan[i]) begin
            s = plan[i].st;
            obs.push_back(int'(db_estado));
            if (contaE === 1'b1) cnt_ce++;
            if (contaL === 1'b1) cnt_cl++;
            n_chk++;
            if (db_estado !== 4'(s)) begin
                $display("FAIL trace[%0d]: db_estado=%0h expected %0h", i, db_estado, s);
                break;
            end else n_pass++;
            n_chk++;
            if (w_outs !== exp_outs(s)) begin
                $display("FAIL outputs[%0d] state %0h: got %b expected %b", i, s, w_outs, exp_outs(s));
            end else n_pass++;
            jogada  = (s == 3) ? plan[i].jog : 1'($urandom_range(1, 0));
            iniciar = (s == 0 || s == 10 || s == 13 || s == 14) ? plan[i].ini : 1'($urandom_range(1, 0));
            if (s == 5) begin
                igual = plan[i].ig; enderecoIgualRodada = plan[i].eir; fimRodadas = plan[i].fim;
            end else begin
                igual = 1'($urandom_range(1, 0));
                enderecoIgualRodada = 1'($urandom_range(1, 0));
                fimRodadas = 1'($urandom_range(1, 0));
            end
            modo_timeout = plan[i].modo;
            step();
        end
        plan.delete();
        jogada = 1'b0;
        iniciar = 1'b0;
    endtask

    function automatic int count_of(input int v);
        count_of = 0;
        foreach (obs[i]) if (obs[i] == v) count_of++;
    endfunction

    task automatic test_reset();
        reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0;
        enderecoIgualRodada = 1'b0; fimRodadas = 1'b0; modo_timeout = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        n_chk++;
        if (db_estado !== 4'h0) $display("FAIL reset_state: got %0h expected 0", db_estado);
        else n_pass++;
        n_chk++;
        if (w_outs !== 10'b1010100000) $display("FAIL reset_outputs: got %b expected 1010100000", w_outs);
        else n_pass++;
        step();
        n_chk++;
        if (db_estado !== 4'h0) $display("FAIL idle_inicial: got %0h expected 0", db_estado);
        else n_pass++;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            n_chk++;
            if (db_estado !== 4'(k)) $display("FAIL start_seq%0d: got %0h expected %0h", k, db_estado, k);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_win_two_rounds();
        int exp_tr[16] = '{0, 1, 2, 3, 4, 5, 7, 2, 3, 4, 5, 6, 3, 4, 5, 10};
        bit ok;
        do_reset();
        g_modo = 1'b1;
        push(0, 0, 1, 0, 0, 0);
        add_game(2, 0, -1, -1, 1'b0);
        run_plan();
        ok = (obs.size() >= 16);
        if (ok) for (int i = 0; i < 16; i++) if (obs[i] != exp_tr[i]) ok = 1'b0;
        n_chk++;
        if (!ok) $display("FAIL win_trace: observed trace differs from 0,1,2,3,4,5,7,2,3,4,5,6,3,4,5,A");
        else n_pass++;
        n_chk++;
        if (cnt_ce != 1 || cnt_cl != 1) $display("FAIL win_pulses: contaE=%0d contaL=%0d expected 1 and 1", cnt_ce, cnt_cl);
        else n_pass++;
        n_chk++;
        if (db_estado !== 4'h1) $display("FAIL win_restart: got %0h expected 1", db_estado);
        else n_pass++;
    endtask

    task automatic test_wrong_move();
        do_reset();
        g_modo = 1'b1;
        push(0, 0, 1, 0, 0, 0);
        add_game(2, 1, 0, 0, 1'b0);
        run_plan();
        n_chk++;
        if (obs.size() == 0 || obs[obs.size()-1] != 14) $display("FAIL wrong_end: last state not E");
        else n_pass++;
        n_chk++;
        if (db_estado !== 4'h1) $display("FAIL wrong_restart: got %0h expected 1", db_estado);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        g_modo = 1'b1;
        push(0, 0, 1, 0, 0, 0);
        add_game(1, int'(TO), -1, -1, 1'b0);
        run_plan();
        n_chk++;
        if (count_of(3) != int'(TO) || count_of(13) != 3)
            $display("FAIL timeout_len: cycles in 3 = %0d expected %0d, D count %0d expected 3", count_of(3), TO, count_of(13));
        else n_pass++;
    endtask

    task automatic test_jogada_on_expiry();
        do_reset();
        g_modo = 1'b1;
        push(0, 0, 1, 0, 0, 0);
        add_game(1, int'(TO) - 1, -1, -1, 1'b0);
        run_plan();
        n_chk++;
        if (count_of(4) != 1 || count_of(13) != 0)
            $display("FAIL expiry_jogada: registra count %0d expected 1, D count %0d expected 0", count_of(4), count_of(13));
        else n_pass++;
    endtask

    task automatic test_no_timeout_mode();
        do_reset();
        g_modo = 1'b0;
        push(0, 0, 1, 0, 0, 0);
        add_game(1, 100, -1, -1, 1'b0);
        run_plan();
        n_chk++;
        if (count_of(3) != 101 || count_of(10) != 3)
            $display("FAIL no_timeout: cycles in 3 = %0d expected 101, A count %0d expected 3", count_of(3), count_of(10));
        else n_pass++;
    endtask

    task automatic test_raise_modo_saturated();
        do_reset();
        g_modo = 1'b0;
        push(0, 0, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0);
        push(2, 0, 0, 0, 0, 0);
        repeat (20) push(3, 0, 0, 0, 0, 0);
        g_modo = 1'b1;
        push(3, 0, 0, 0, 0, 0);
        push(13, 0, 0, 0, 0, 0);
        push(13, 0, 1, 0, 0, 0);
        run_plan();
        n_chk++;
        if (db_estado !== 4'h1) $display("FAIL raise_modo_restart: got %0h expected 1", db_estado);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        g_modo = 1'b1;
        push(0, 0, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0);
        push(2, 0, 0, 0, 0, 0);
        push(3, 1, 0, 0, 0, 0);
        push(4, 0, 0, 0, 0, 0);
        run_plan();
        n_chk++;
        if (db_estado !== 4'h5) $display("FAIL areset_pre: got %0h expected 5", db_estado);
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_chk++;
        if (db_estado !== 4'h0 || {pronto, ganhou, perdeu, timeout} !== 4'b0000)
            $display("FAIL areset_now: db_estado=%0h flags=%b expected 0 and 0000", db_estado, {pronto, ganhou, perdeu, timeout});
        else n_pass++;
        step();
        reset = 1'b1;
    endtask

    task automatic test_random_games();
        int exp_ce;
        int exp_cl;
        do_reset();
        push(0, 0, 1, 0, 0, 0);
        for (int g = 0; g < 25; g++) begin
            g_modo = 1'($urandom_range(1, 0));
            add_game(int'($urandom_range(4, 1)), 0, -1, -1, 1'b1);
        end
        exp_ce = 0;
        exp_cl = 0;
        foreach (plan[i]) begin
            if (plan[i].st == 6) exp_ce++;
            if (plan[i].st == 7) exp_cl++;
        end
        run_plan();
        n_chk++;
        if (cnt_ce != exp_ce || cnt_cl != exp_cl)
            $display("FAIL random_pulses: contaE=%0d contaL=%0d expected %0d and %0d", cnt_ce, cnt_cl, exp_ce, exp_cl);
        else n_pass++;
        n_chk++;
        if (db_estado !== 4'h1) $display("FAIL random_restart: got %0h expected 1", db_estado);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_win_two_rounds();
        test_wrong_move();
        test_timeout();
        test_jogada_on_expiry();
        test_no_timeout_mode();
        test_raise_modo_saturated();
        test_async_reset();
        test_random_games();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
